// File: rtl/result_pkg.sv
// Shared types and constants for the result collector slice.
package result_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    TIMEOUT = 2'd2
  } collector_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extended pointers; the parent owns all drop policy.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/result_collector.sv
// Captures engine results on the valid rising edge, buffers them and flags protocol errors.
module result_collector
  import result_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              eng_start,
  input  logic              eng_valid,
  input  logic [DATA_W-1:0] eng_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              clr_err,
  output logic              err_timeout,
  output logic              err_spurious,
  output logic              err_overflow,
  output logic [CNT_W-1:0]  result_cnt
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

  collector_state_t    state;
  collector_state_t    state_nxt;
  logic [TIMER_W-1:0]  timer;
  logic [TIMER_W-1:0]  timer_nxt;
  logic                valid_q;
  logic                cap;
  logic                push_req;
  logic                push;
  logic                pop;
  logic                timeout_evt;
  logic                spurious_evt;
  logic                overflow_evt;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DATA_W-1:0]   fifo_head;

  // One capture per valid assertion, however long valid is held.
  assign cap = eng_valid & ~valid_q;

  // A capture is accepted if there is room now or a slot frees this cycle.
  assign pop          = ~fifo_empty & out_ready;
  assign push         = push_req & (~fifo_full | pop);
  assign overflow_evt = push_req & ~push;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, timer and event decode.
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    push_req     = 1'b0;
    timeout_evt  = 1'b0;
    spurious_evt = 1'b0;
    case (state)
      IDLE: begin
        if (cap) spurious_evt = 1'b1;
        if (eng_start) begin
          state_nxt = BUSY;
          timer_nxt = '0;
        end
      end
      BUSY: begin
        if (timer != '1) timer_nxt = timer + TIMER_W'(1);
        if (cap) begin
          push_req = 1'b1;
          if (eng_start) begin
            state_nxt = BUSY;
            timer_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (timer == TIMER_LAST) begin
          state_nxt   = TIMEOUT;
          timeout_evt = 1'b1;
        end
      end
      TIMEOUT: begin
        if (cap) spurious_evt = 1'b1;
        if (clr_err) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Edge register, timer, sticky flags (new events beat clear) and result counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      timer        <= '0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
      err_overflow <= 1'b0;
      result_cnt   <= '0;
    end else begin
      valid_q      <= eng_valid;
      timer        <= timer_nxt;
      err_timeout  <= timeout_evt  | (err_timeout  & ~clr_err);
      err_spurious <= spurious_evt | (err_spurious & ~clr_err);
      err_overflow <= overflow_evt | (err_overflow & ~clr_err);
      if (push) result_cnt <= result_cnt + CNT_W'(1);
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (eng_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_head;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector with a queue-based output scoreboard.
module tb_result_collector;

  logic        clk;
  logic        rst_n;
  logic        eng_start;
  logic        eng_valid;
  logic [7:0]  eng_data;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        clr_err;
  logic        err_timeout;
  logic        err_spurious;
  logic        err_overflow;
  logic [15:0] result_cnt;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp_q [$];

  result_collector #(
    .DATA_W      (8),
    .DEPTH       (4),
    .TIMEOUT_CYC (1024)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .eng_start    (eng_start),
    .eng_valid    (eng_valid),
    .eng_data     (eng_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .clr_err      (clr_err),
    .err_timeout  (err_timeout),
    .err_spurious (err_spurious),
    .err_overflow (err_overflow),
    .result_cnt   (result_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    eng_start = 1'b0;
    eng_valid = 1'b0;
    eng_data  = 8'h00;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    eng_start = 1'b1;
    tick();
    eng_start = 1'b0;
  endtask

  task automatic send_valid(input logic [7:0] d, input int hold);
    eng_valid = 1'b1;
    eng_data  = d;
    repeat (hold) tick();
    eng_valid = 1'b0;
    tick();
  endtask

  task automatic pair(input logic [7:0] d);
    pulse_start();
    tick();
    send_valid(d, 1);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tick();
  endtask

  // Monitor: compares every accepted beat against the scoreboard queue.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got %0h, expected no beat", out_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 32'(out_data), 32'(e));
        end
      end
    end
  end

  initial begin
    do_reset();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_result_cnt", 32'(result_cnt), 0);
    check("rst_flags", 32'({err_timeout, err_spurious, err_overflow}), 0);

    // 1: basic capture with valid held two cycles
    out_ready = 1'b1;
    pulse_start();
    repeat (8) tick();
    exp_q.push_back(8'h5A);
    send_valid(8'h5A, 2);
    repeat (3) tick();
    check("t1_result_cnt", 32'(result_cnt), 1);
    check("t1_flags", 32'({err_timeout, err_spurious, err_overflow}), 0);
    check("t1_drained", 32'(exp_q.size()), 0);

    // 2: backpressure and overflow
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      pair(8'(i));
    end
    check("t2_overflow", 32'(err_overflow), 1);
    check("t2_result_cnt", 32'(result_cnt), 4);
    check("t2_head", 32'(out_data), 32'h01);
    tick();
    check("t2_head_stable", 32'(out_data), 32'h01);
    out_ready = 1'b1;
    repeat (6) tick();
    check("t2_drained", 32'(exp_q.size()), 0);
    check("t2_empty", 32'(out_valid), 0);

    // 3: capture while full in the same cycle as a pop
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(8'h11 + i));
      pair(8'(8'h11 + i));
    end
    exp_q.push_back(8'h15);
    pulse_start();
    tick();
    eng_valid = 1'b1;
    eng_data  = 8'h15;
    out_ready = 1'b1;
    tick();
    eng_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    check("t3_no_overflow", 32'(err_overflow), 0);
    check("t3_result_cnt", 32'(result_cnt), 5);
    check("t3_head", 32'(out_data), 32'h12);
    out_ready = 1'b1;
    repeat (6) tick();
    check("t3_drained", 32'(exp_q.size()), 0);

    // 4: timeout, late valid, clear
    do_reset();
    out_ready = 1'b1;
    pulse_start();
    repeat (1023) tick();
    check("t4_timeout_early", 32'(err_timeout), 0);
    tick();
    check("t4_timeout_exact", 32'(err_timeout), 1);
    send_valid(8'h77, 1);
    check("t4_spurious", 32'(err_spurious), 1);
    check("t4_no_push", 32'(out_valid), 0);
    pulse_clr();
    check("t4_cleared", 32'({err_timeout, err_spurious}), 0);
    exp_q.push_back(8'h42);
    pair(8'h42);
    tick();
    check("t4_idle_capture_cnt", 32'(result_cnt), 1);
    check("t4_drained", 32'(exp_q.size()), 0);

    // 5: spurious edge while idle
    send_valid(8'hFF, 1);
    check("t5_spurious", 32'(err_spurious), 1);
    check("t5_out_valid", 32'(out_valid), 0);
    check("t5_result_cnt", 32'(result_cnt), 1);
    pulse_clr();
    check("t5_cleared", 32'(err_spurious), 0);

    // 6: reset mid-flight discards FIFO and outstanding request
    out_ready = 1'b0;
    pair(8'hA1);
    pair(8'hA2);
    pulse_start();
    check("t6_pre_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_out_valid", 32'(out_valid), 0);
    check("t6_out_data", 32'(out_data), 0);
    check("t6_result_cnt", 32'(result_cnt), 0);
    check("t6_flags", 32'({err_timeout, err_spurious, err_overflow}), 0);
    out_ready = 1'b1;
    send_valid(8'h33, 1);
    check("t6_idle_spurious", 32'(err_spurious), 1);
    check("t6_no_beat", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
